// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// Pure declarations; no logic, no latency, no flow control.
package serial_add_pkg;

   localparam int   SAS_WIDTH = 8;
   localparam logic OP_ADD    = 1'b0;
   localparam logic OP_SUB    = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/fa_bit.sv
// Single full-adder cell built from two half-adder stages and a carry OR.
// Purely combinational (zero latency); no flow control.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;
   logic g;
   logic pc;

   always_comb begin
      p    = a ^ b;
      g    = a & b;
      s    = p ^ cin;
      pc   = p & cin;
      cout = g | pc;
   end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial a+b / a-b through one full-adder cell, LSB first; done pulses WIDTH+1 cycles after start.
// No backpressure: start is taken only in IDLE or DONE and silently ignored while busy.
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SAS_WIDTH,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sha_q, sha_d;
   logic [WIDTH-1:0] shb_q, shb_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_s;
   logic             fa_co;

   fa_bit u_fa (
      .a    (sha_q[0]),
      .b    (shb_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_co)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      carry_d = carry_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               // Subtract as a + ~b + 1: the +1 enters through the initial carry.
               sha_d   = a;
               shb_d   = (op == OP_ADD) ? b : ~b;
               carry_d = op;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            carry_d = fa_co;
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // Visible outputs only change here, so sum shows the prior result while shifting.
               sum_d   = {fa_s, res_q[WIDTH-1:1]};
               cout_d  = fa_co;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sha_q   <= '0;
         shb_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: expected results come from plain integer arithmetic.
// A negedge monitor pops and compares on every done pulse and checks hold/latency in between.
module tb_serial_add_seq;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   serial_add_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t r;
      int   s;
      if (o) begin
         s   = int'(x) - int'(y);
         r.c = (x >= y);
      end else begin
         s   = int'(x) + int'(y);
         r.c = (s >= (1 << W));
      end
      r.s = s[W-1:0];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
      end
   endtask

   // Issued at a negedge while the DUT is in IDLE or DONE; start is taken at the next posedge.
   task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      exp_q.push_back(model(o, x, y));
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      op    = ~o;
   endtask

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 3 * W + 10 && !got; i++) begin
         if (done) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done, want done within %0d cycles", 3 * W + 10);
      end
   endtask

   // Monitor: compares on done, checks busy run length, pulse width and output hold.
   initial begin
      int   run;
      bit   prev_done;
      exp_t held;
      exp_t e;
      run       = 0;
      prev_done = 1'b0;
      held.s    = '0;
      held.c    = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run       = 0;
            prev_done = 1'b0;
            held.s    = '0;
            held.c    = 1'b0;
         end else begin
            if (busy) run++;
            if (done) begin
               chk("busy_cycles", run, W);
               chk("done_width", {31'd0, prev_done}, 32'd0);
               chk("busy_in_done", {31'd0, busy}, 32'd0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_done: got done with sum %0h, want no done", sum);
               end else begin
                  e = exp_q.pop_front();
                  chk("sum", sum, e.s);
                  chk("cout", {31'd0, cout}, {31'd0, e.c});
                  held = e;
               end
               run = 0;
            end else begin
               chk("sum_hold", sum, held.s);
               chk("cout_hold", {31'd0, cout}, {31'd0, held.c});
            end
            prev_done = done;
         end
      end
   end

   initial begin
      logic         ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rst_n = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", sum, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      do_op(1'b0, 8'h5A, 8'h3C);
      wait_done();
      @(negedge clk);
      do_op(1'b0, 8'hFF, 8'h01);
      wait_done();
      @(negedge clk);
      do_op(1'b1, 8'h10, 8'h20);
      wait_done();
      @(negedge clk);
      do_op(1'b1, 8'h20, 8'h10);
      wait_done();
      @(negedge clk);

      // Start pulse mid-SHIFT with other operands must be dropped.
      do_op(1'b0, 8'h11, 8'h22);
      repeat (2) @(negedge clk);
      op    = 1'b1;
      a     = 8'hE7;
      b     = 8'h3D;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (20) @(negedge clk);

      // Back-to-back: the second start is driven during the DONE cycle.
      do_op(1'b0, 8'h05, 8'h06);
      wait_done();
      do_op(1'b0, 8'h01, 8'h02);
      wait_done();
      @(negedge clk);

      do_op(1'b0, 8'hC3, 8'h11);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_sum", sum, 32'd0);
      chk("arst_cout", {31'd0, cout}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      do_op(1'b0, 8'h7F, 8'h01);
      wait_done();

      for (int i = 0; i < 40; i++) begin
         ro = 1'($urandom_range(0, 1));
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 10 == 0) rb = ra;
         do_op(ro, ra, rb);
         wait_done();
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (W + 5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Bit-serial add/subtract sequencer that sits directly upstream of the half-adder output logic in the tt_um top.
- Accepts two WIDTH-bit operands on a start strobe and shifts them LSB-first through a single full-adder cell, one bit per clock.
- Presents the registered WIDTH-bit result and carry to the top-level output pins.
- Trades area for latency: one adder cell in place of WIDTH cells.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..16).
- CW, $clog2(WIDTH), bit-counter width (derived; do not override).

Ports:
- clk    input   1      system clock, rising-edge.
- rst_n  input   1      asynchronous active-low reset.
- start  input   1      request; sampled every rising edge.
- op     input   1      0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a      input   WIDTH  operand A; sampled with start.
- b      input   WIDTH  operand B; sampled with start.
- busy   output  1      high while bits are being processed.
- done   output  1      one-cycle pulse when the result is valid.
- sum    output  WIDTH  result; held until the next accepted start.
- cout   output  1      final carry; in subtract mode, 1 = no borrow.

Behaviour:
- Interface: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, operand shift registers=0, carry flop=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge latches a into shA.
  - Latches b into shB for op=0, or ~b for op=1.
  - Sets carry=op and count=0.
  - Next state SHIFT.
- SHIFT:
  - Each cycle, bit s = shA[0]^shB[0]^carry.
  - carry <= (shA[0]&shB[0]) | (carry&(shA[0]^shB[0])).
  - shA and shB shift right by 1; s is shifted into the MSB of the result register.
  - count increments.
  - When count==WIDTH-1 is processed, next state is DONE.
  - busy=1 throughout SHIFT.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - sum holds the full result; cout holds the final carry.
  - start=1 in this cycle is accepted exactly as in IDLE, and the next state is SHIFT (back-to-back).
  - Otherwise the next state is IDLE.
- Latency: start sampled at edge N → busy high in cycles N+1..N+WIDTH → done high in cycle N+WIDTH+1.
- sum and cout are driven from registers only; there is no combinational path from inputs to outputs.
- sum/cout keep their last value from DONE through IDLE until the DONE of the next operation.
- The result register is a separate shift register; sum reflects it only while DONE or IDLE.
- During SHIFT, sum shows the previous result (a shadow copy is updated on entry to DONE).
- start while in SHIFT is ignored (no queueing), and op/a/b changes during SHIFT have no effect.
- Wrap-around: the add result is modulo 2^WIDTH, with overflow reported only via cout.
- Subtract is two's complement: a-b mod 2^WIDTH, cout=1 iff a>=b (unsigned).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the partial result is discarded.

Decomposition:
- Package serial_add_pkg holds:
  - the state enum {IDLE, SHIFT, DONE} (2-bit encoding);
  - OP_ADD=1'b0 and OP_SUB=1'b1;
  - a default WIDTH constant.
- Sub-module fa_bit: a combinational full-adder cell built from two half-adder stages (xor/and) plus an OR for carry. It is instantiated once inside serial_add_seq and is reusable by the top-level half-adder path.

Test Plan:
- Add: reset, then start with op=0, a=8'h5A, b=8'h3C → busy high 8 cycles, done pulse 9 cycles after the start edge, sum=8'h96, cout=0.
- Add with wrap: op=0, a=8'hFF, b=8'h01 → sum=8'h00, cout=1, done one cycle wide.
- Subtract: op=1, a=8'h10, b=8'h20 → sum=8'hF0, cout=0. Then op=1, a=8'h20, b=8'h10 → sum=8'h10, cout=1.
- Ignore and hold:
  - Start pulses with different operands 3 cycles after the first start (mid-SHIFT) → ignored; result equals the first operation, and only one done pulse occurs.
  - sum stays stable while IDLE for 20 cycles.
- Back-to-back: assert start with new operands (8'h01+8'h02) in the DONE cycle of 8'h05+8'h06 → first done shows 8'h0B, second done 9 cycles later shows 8'h03, busy has no idle gap.
- Reset mid-operation: drop rst_n 4 cycles into SHIFT, asynchronously between edges → busy/done/sum/cout go 0 immediately. After release, a fresh 8'h7F+8'h01 gives 8'h80, cout=0.
